instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//  - Fetch stage directly upstream of the instruction memory: owns the fetch PC, drives pc_addr_o, captures the returned word.
//  - Buffers {pc, instr} pairs in a DEPTH-entry prefetch queue feeding decode (IF/ID) through a valid/ready handshake.
//  - Branch/jump redirect flushes the queue and restarts fetch at the new PC.
// PARAMETERS
//  - DEPTH     4             queue entries; power of two, 2..16
//  - RESET_PC  32'h0000_0000 fetch PC loaded on reset
// PORTS
//  - clk_i            in   1   single clock, all state on rising edge
//  - rst_i            in   1   asynchronous, active-low reset
//  - pc_addr_o        out  32  fetch address to instruction memory (= fetch_pc)
//  - instr_i          in   32  word from instruction memory; combinational, valid same cycle as pc_addr_o
//  - redirect_i       in   1   taken branch/jump: flush and refetch
//  - redirect_pc_i    in   32  new fetch PC; bits [1:0] forced to 0
//  - instr_valid_o    out  1   queue head valid
//  - instr_ready_i    in   1   decode accepts head this cycle
//  - instr_o          out  32  head instruction (32'b0 when empty)
//  - instr_pc_o       out  32  head PC (32'b0 when empty)
//  - fetch_cnt_o      out  32  [IFQ_PERF_CNT_EN only] words pushed
//  - stall_cnt_o      out  32  [IFQ_PERF_CNT_EN only] cycles FSM in FULL
// BEHAVIOUR
//  - Reset (rst_i=0, async): fetch_pc=RESET_PC, count=0, rd/wr ptrs=0, FSM=FETCH, instr_valid_o=0, instr_o=0, instr_pc_o=0, counters=0.
//  - pop = instr_valid_o & instr_ready_i. push = !redirect_i & (count<DEPTH | pop).
//  - Push writes {fetch_pc, instr_i} at wr ptr; fetch_pc <= fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
//  - No push: fetch_pc holds; pc_addr_o keeps driving it.
//  - Simultaneous push+pop with count==DEPTH: both occur, count unchanged.
//  - Latency: word at pc_addr_o in cycle N is at head in cycle N+1 earliest (queue was empty).
//  - Outputs registered from queue state; instr_o/instr_pc_o stable while valid & !ready.
//  - Redirect (highest priority): next edge count=0, ptrs=0, fetch_pc=redirect_pc_i&~3, FSM=FETCH;
//    no push that cycle; head in same cycle is discarded even if popped (decode treats redirect as kill).
//  - First instruction at redirect target appears at head 2 cycles after redirect_i asserted.
//  - Redirect while empty or full: identical behaviour.
//  - FSM: FETCH -> FULL when count becomes DEPTH with no pop; FULL -> FETCH on pop or redirect.
//    In FULL no push unless same-cycle pop; pc_addr_o held.
//  - Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits; never exceeds DEPTH.
//  - Reset mid-operation: all entries dropped; fetch restarts at RESET_PC after deassert.
// CONFIGURATION
//  - IFQ_PERF_CNT_EN defined: fetch_cnt_o +1 per push, stall_cnt_o +1 per cycle in FULL;
//    both 32-bit wrapping, cleared only by reset (not by redirect).
//  - Undefined: both ports and counters absent; no other behaviour change.
// STRUCTURE
//  - Shared package ifq_pkg: RESET_PC default, FSM state encodings (FETCH=0, FULL=1),
//    entry layout constant ENTRY_W=64 ({pc[63:32], instr[31:0]}).
//  - Sub-module ifq_fifo: generic sync FIFO (DEPTH, ENTRY_W) with push/pop/flush, count, registered head.
//  - Top holds fetch_pc, FSM, redirect logic, optional counters.
// TESTING
//  - Reset, ready=1, mem[i]=i+1: pc_addr_o 0,4,8...; head pairs (0,1),(4,2),(8,3) on consecutive cycles.
//  - ready=0 for 10 cycles: count reaches 4, FSM FULL, pc_addr_o frozen at 16, head stays (0,1); ready=1 drains in order.
//  - Full + ready=1 steady: push and pop every cycle, count stays 4, no entry lost or duplicated.
//  - redirect_i with redirect_pc_i=32'h0000_0042 while full: next cycle valid=0, pc_addr_o=32'h40; head (32'h40,mem[16]) one cycle later.
//  - Redirect_pc_i=32'hFFFF_FFFC: after push, pc_addr_o wraps to 0.
//  - rst_i low mid-drain: outputs 0 immediately (async); with IFQ_PERF_CNT_EN, both counters 0; stall_cnt_o counts exact FULL cycles.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: reset PC default, FSM encoding, entry layout.
package ifq_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Queue entry layout: {pc[63:32], instr[31:0]}
    localparam int unsigned ENTRY_W = 64;

    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StFull  = 1'b1
    } ifq_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with flush and a registered head (data is zero when empty).
module ifq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthC = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    count_q, count_d, remain;
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop       = pop & (count_q != '0);
        do_push      = push & ((count_q != DepthC) | do_pop);
        rd_ptr_d     = rd_ptr_q + PtrW'(do_pop);
        wr_ptr_d     = wr_ptr_q + PtrW'(do_push);
        count_d      = count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        remain       = count_q - (PtrW + 1)'(do_pop);
        head_valid_d = 1'b0;
        head_data_d  = '0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (count_d != '0) begin
            head_valid_d = 1'b1;
            // Nothing left behind the popped head: the new head is the word written now
            head_data_d  = (remain == '0) ? wdata : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    assign head_valid = head_valid_q;
    assign head_data  = head_data_q;
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, buffers {pc, instr} pairs for decode, flushes on redirect.
// Optional performance counters are enabled with `define IFQ_PERF_CNT_EN.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_addr_o,
    input  logic [31:0] instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthC = (PtrW + 1)'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    ifq_state_e       state_q, state_d;
    logic             push, pop;
    logic [PtrW:0]    count, count_after;
    logic [ENTRY_W-1:0] head_data;

    assign pop  = instr_valid_o & instr_ready_i;
    // FULL implies count == DEPTH, so only a same-cycle pop makes room
    assign push = ~redirect_i & (pop | ((state_q != StFull) & (count != DepthC)));
    assign count_after = count + (PtrW + 1)'(push) - (PtrW + 1)'(pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        if (redirect_i) begin
            fetch_pc_d = align_pc(redirect_pc_i);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        unique case (state_q)
            StFetch: begin
                if (!redirect_i && !pop && (count_after == DepthC)) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (redirect_i || pop) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q <= RESET_PC;
            state_q    <= StFetch;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            state_q    <= state_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush      (redirect_i),
        .push       (push),
        .pop        (pop),
        .wdata      ({fetch_pc_q, instr_i}),
        .head_valid (instr_valid_o),
        .head_data  (head_data),
        .count      (count)
    );

    assign pc_addr_o  = fetch_pc_q;
    assign instr_o    = head_data[31:0];
    assign instr_pc_o = head_data[63:32];

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Redirect does not clear these; only reset does
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (state_q == StFull) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
